// File: rtl/seq_gen_pkg.sv
// Shared definitions for the serial sequence generator: state codes,
// FSM state type and a counter-width helper.
package seq_gen_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_SEND = S_SEND,
    ST_GAP  = S_GAP,
    ST_DONE = S_DONE
  } state_t;

  // ceil(log2(v)), never below 1 so degenerate counters still have a bit
  function automatic int unsigned cnt_w(input int unsigned v);
    int unsigned r;
    r = 32'd0;
    while ((32'd1 << r) < v) begin
      r = r + 32'd1;
    end
    return (r == 32'd0) ? 32'd1 : r;
  endfunction

endpackage

// File: rtl/seq_gen_if.sv
// Request/serial-output bundle of seq_gen; master issues requests, slave transmits.
interface seq_gen_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [CNT_W-1:0] repeat_cnt;
  logic             abort;
  logic             o;
  logic             o_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, repeat_cnt, abort,
    input  o, o_valid, busy, done
  );

  modport slave (
    input  start, pattern, repeat_cnt, abort,
    output o, o_valid, busy, done
  );
endinterface

// File: rtl/seq_gen_shreg.sv
// Parallel-load shift register presenting its MSB; shifts toward the MSB.
module seq_gen_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             q_msb
);

  logic [WIDTH-1:0] data_r;

  // load has priority over shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r <= '0;
    end else if (load) begin
      data_r <= d;
    end else if (shift) begin
      data_r <= {data_r[WIDTH-2:0], 1'b0};
    end else begin
      data_r <= data_r;
    end
  end

  assign q_msb = data_r[WIDTH-1];

endmodule

// File: rtl/seq_gen.sv
// Serial sequence generator: sends a captured pattern MSB-first, repeat_cnt+1
// times, with optional idle gaps between frames and a done pulse at the end.
module seq_gen
  import seq_gen_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter int   CNT_W      = 4,
  parameter int   GAP        = 2,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  seq_gen_if.slave   bus
);

  localparam int BIT_W = cnt_w(WIDTH);
  localparam int GAP_W = cnt_w(GAP + 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP > 0) ? (GAP - 1) : 0);

  state_t           state_r;
  logic [WIDTH-1:0] hold_r;
  logic [CNT_W-1:0] reps_r;
  logic [BIT_W-1:0] bit_cnt_r;
  logic [GAP_W-1:0] gap_cnt_r;
  logic             o_r;
  logic             o_valid_r;
  logic             busy_r;
  logic             done_r;

  logic             load_s;
  logic             shift_s;
  logic [WIDTH-1:0] ld_data_s;
  logic             sh_msb_s;

  // The MSB goes straight to o on a (re)load, so the shifter holds only the
  // remaining bits and its MSB is always the next bit to send.
  always_comb begin
    load_s  = 1'b0;
    shift_s = 1'b0;
    if (state_r == ST_IDLE) begin
      ld_data_s = {bus.pattern[WIDTH-2:0], 1'b0};
    end else begin
      ld_data_s = {hold_r[WIDTH-2:0], 1'b0};
    end
    if (bus.abort) begin
      load_s  = 1'b0;
      shift_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: load_s = bus.start;
        ST_SEND: begin
          if (bit_cnt_r != '0) begin
            shift_s = 1'b1;
          end else if ((reps_r != '0) && (GAP == 32'sd0)) begin
            load_s = 1'b1;
          end else begin
            shift_s = 1'b0;
          end
        end
        ST_GAP: begin
          if (gap_cnt_r == '0) begin
            load_s = 1'b1;
          end else begin
            load_s = 1'b0;
          end
        end
        default: load_s = 1'b0;
      endcase
    end
  end

  seq_gen_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_s),
    .shift (shift_s),
    .d     (ld_data_s),
    .q_msb (sh_msb_s)
  );

  // FSM with counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      hold_r    <= '0;
      reps_r    <= '0;
      bit_cnt_r <= '0;
      gap_cnt_r <= '0;
      o_r       <= IDLE_LEVEL;
      o_valid_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else if (bus.abort) begin
      state_r   <= ST_IDLE;
      o_r       <= IDLE_LEVEL;
      o_valid_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            state_r   <= ST_SEND;
            hold_r    <= bus.pattern;
            reps_r    <= bus.repeat_cnt;
            bit_cnt_r <= BIT_LAST;
            o_r       <= bus.pattern[WIDTH-1];
            o_valid_r <= 1'b1;
            busy_r    <= 1'b1;
          end else begin
            o_r       <= IDLE_LEVEL;
            o_valid_r <= 1'b0;
            busy_r    <= 1'b0;
          end
        end
        ST_SEND: begin
          if (bit_cnt_r != '0) begin
            o_r       <= sh_msb_s;
            bit_cnt_r <= bit_cnt_r - BIT_W'(1);
          end else if (reps_r == '0) begin
            state_r   <= ST_DONE;
            o_r       <= IDLE_LEVEL;
            o_valid_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
          end else if (GAP > 32'sd0) begin
            state_r   <= ST_GAP;
            o_r       <= IDLE_LEVEL;
            o_valid_r <= 1'b0;
            gap_cnt_r <= GAP_LOAD;
            reps_r    <= reps_r - CNT_W'(1);
          end else begin
            o_r       <= hold_r[WIDTH-1];
            bit_cnt_r <= BIT_LAST;
            reps_r    <= reps_r - CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (gap_cnt_r == '0) begin
            state_r   <= ST_SEND;
            o_r       <= hold_r[WIDTH-1];
            o_valid_r <= 1'b1;
            bit_cnt_r <= BIT_LAST;
          end else begin
            gap_cnt_r <= gap_cnt_r - GAP_W'(1);
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
        end
        default: begin
          state_r   <= ST_IDLE;
          o_r       <= IDLE_LEVEL;
          o_valid_r <= 1'b0;
          busy_r    <= 1'b0;
          done_r    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o       = o_r;
  assign bus.o_valid = o_valid_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;

endmodule

// File: tb/tb_seq_gen.sv
// Bench for seq_gen: a GAP=2 and a GAP=0 instance share stimulus and are each
// compared cycle by cycle against a frame-list model of the expected waveform.
module tb_seq_gen;

  localparam int W  = 8;
  localparam int CW = 4;

  typedef logic [3:0] ent_t;   // {o, o_valid, busy, done}
  typedef ent_t ent_q_t[$];

  localparam ent_t E_IDLE = 4'b1000;
  localparam ent_t E_GAP  = 4'b1010;
  localparam ent_t E_DONE = 4'b1001;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  seq_gen_if #(.WIDTH(W), .CNT_W(CW)) bus2 ();
  seq_gen_if #(.WIDTH(W), .CNT_W(CW)) bus0 ();

  seq_gen #(.WIDTH(W), .CNT_W(CW), .GAP(2), .IDLE_LEVEL(1'b1)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );
  seq_gen #(.WIDTH(W), .CNT_W(CW), .GAP(0), .IDLE_LEVEL(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic drive_in(input logic s, input logic [W-1:0] p, input logic [CW-1:0] r, input logic a);
    bus2.start = s; bus2.pattern = p; bus2.repeat_cnt = r; bus2.abort = a;
    bus0.start = s; bus0.pattern = p; bus0.repeat_cnt = r; bus0.abort = a;
  endtask

  task automatic check_both(input string tag, input ent_t e2, input ent_t e0);
    check_eq({tag, ".g2"}, {28'd0, bus2.o, bus2.o_valid, bus2.busy, bus2.done}, {28'd0, e2});
    check_eq({tag, ".g0"}, {28'd0, bus0.o, bus0.o_valid, bus0.busy, bus0.done}, {28'd0, e0});
  endtask

  // Expected per-cycle outputs from cycle 1 after the accepted start:
  // frames of pattern bits, gap cycles between frames, done, then idle.
  task automatic build_exp(input logic [W-1:0] pat, input int rc, input int gap,
                           input int ab, output ent_q_t q);
    q = {};
    for (int f = 0; f <= rc; f++) begin
      for (int i = W - 1; i >= 0; i--) q.push_back({pat[i], 3'b110});
      if (f < rc) for (int g = 0; g < gap; g++) q.push_back(E_GAP);
    end
    q.push_back(E_DONE);
    if (ab > 0 && ab < q.size()) begin
      while (q.size() > ab) void'(q.pop_back());
    end
    q.push_back(E_IDLE);
  endtask

  task automatic run_txn(input string tag, input logic [W-1:0] pat, input int rc,
                         input int ab, input bit noise);
    ent_q_t q2, q0;
    int len, lim;
    ent_t e2, e0;
    build_exp(pat, rc, 2, ab, q2);
    build_exp(pat, rc, 0, ab, q0);
    len = (q2.size() > q0.size()) ? q2.size() : q0.size();
    lim = ((q2.size() < q0.size()) ? q2.size() : q0.size()) - 1;
    @(negedge clk);
    drive_in(1'b1, pat, CW'(rc), 1'b0);
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      e2 = (k - 1 < q2.size()) ? q2[k-1] : E_IDLE;
      e0 = (k - 1 < q0.size()) ? q0[k-1] : E_IDLE;
      check_both($sformatf("%s.c%0d", tag, k), e2, e0);
      drive_in((noise && k <= lim) ? 1'($urandom) : 1'b0, W'($urandom),
               CW'($urandom), (k == ab));
    end
    drive_in(1'b0, W'($urandom), CW'($urandom), 1'b0);
  endtask

  initial begin
    logic [W-1:0] pat;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b1;
    drive_in(1'b1, 8'hA5, 4'd0, 1'b0);
    #1 rst_n = 1'b0;

    // reset held with start high: nothing may start
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_both($sformatf("rst.c%0d", c), E_IDLE, E_IDLE);
    end
    drive_in(1'b0, 8'hA5, 4'd0, 1'b0);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_both($sformatf("rel.c%0d", c), E_IDLE, E_IDLE);
    end

    run_txn("b2", 8'b1011_0010, 0, 0, 1'b0);
    run_txn("a5r2", 8'hA5, 2, 0, 1'b0);
    run_txn("f0r1", 8'hF0, 1, 0, 1'b0);
    run_txn("a5nz", 8'hA5, 0, 0, 1'b1);
    run_txn("abrt3", 8'hC3, 1, 3, 1'b0);
    run_txn("abrtgap", 8'h5A, 1, 9, 1'b0);

    // asynchronous reset in the middle of a frame
    @(negedge clk);
    drive_in(1'b1, 8'h96, 4'd3, 1'b0);
    @(negedge clk);
    drive_in(1'b0, 8'h00, 4'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_both("arst.now", E_IDLE, E_IDLE);
    @(negedge clk);
    check_both("arst.held", E_IDLE, E_IDLE);
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check_both($sformatf("arst.post%0d", c), E_IDLE, E_IDLE);
    end
    run_txn("fresh", 8'h69, 1, 0, 1'b0);

    for (int t = 0; t < 12; t++) begin
      pat = W'($urandom);
      run_txn($sformatf("rnd%0d", t), pat, $urandom_range(0, 3),
              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 0,
              1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
